// File: rtl/sync_rr_pkg.sv
// Shared types and helpers for the synchronised round-robin arbiter.
// Build option: SYNC_RR_THREE_STAGE_EN selects a 3-flop request synchroniser (default 2).
package sync_rr_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

`ifdef SYNC_RR_THREE_STAGE_EN
   localparam int unsigned SYNC_STAGES = 3;
`else
   localparam int unsigned SYNC_STAGES = 2;
`endif

   // Widest supported configuration; rr_pick works on zero-extended vectors.
   localparam int unsigned MAX_N   = 16;
   localparam int unsigned MAX_IDW = 4;

   typedef struct packed {
      logic               valid;
      logic [MAX_IDW-1:0] idx;
   } pick_t;

   // First set bit of req searching last+1, last+2, ... modulo n.
   function automatic pick_t rr_pick(input logic [MAX_N-1:0]   req,
                                     input logic [MAX_IDW-1:0] last,
                                     input int unsigned        n);
      pick_t       pick;
      int unsigned cand;
      pick = '0;
      for (int unsigned i = 1; i <= MAX_N; i++) begin
         cand = (32'(last) + i) % n;
         if (i <= n && !pick.valid && req[cand[MAX_IDW-1:0]]) begin
            pick.valid = 1'b1;
            pick.idx   = cand[MAX_IDW-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sync_rr_arbiter_sync_vec.sv
// Width-W, S-stage flop synchroniser with synchronous active-low clear.
module sync_vec #(
   parameter int unsigned W = 4,
   parameter int unsigned S = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sync_q [S];

   // Shift the asynchronous inputs through the flop chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < S; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int unsigned i = 1; i < S; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[S-1];

endmodule

// File: rtl/sync_rr_arbiter.sv
// Round-robin arbiter with synchronised level requests and a four-phase grant handshake.
// Build option: SYNC_RR_THREE_STAGE_EN (see sync_rr_pkg) lengthens the synchroniser only.
module sync_rr_arbiter
   import sync_rr_pkg::*;
#(
   parameter int unsigned  N   = 4,
   localparam int unsigned IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy
);

   logic [N-1:0]   req_s;
   state_t         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [IDW-1:0] last_q, last_d;
   pick_t          pick;

   sync_vec #(
      .W(N),
      .S(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (req),
      .q_o  (req_s)
   );

   // Round-robin winner among synchronised requests, starting after the last owner.
   always_comb begin
      pick = rr_pick(MAX_N'(req_s), MAX_IDW'(last_q), N);
   end

   // Grant FSM: grant only from IDLE, hold while the owner requests, then one GAP cycle.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      last_d   = last_q;
      unique case (state_q)
         IDLE: begin
            if (pick.valid) begin
               gnt_d                     = '0;
               gnt_d[pick.idx[IDW-1:0]]  = 1'b1;
               gnt_id_d                  = pick.idx[IDW-1:0];
               state_d                   = GRANT;
            end
         end
         GRANT: begin
            if (!req_s[gnt_id_q]) begin
               gnt_d   = '0;
               last_d  = gnt_id_q;
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset drops any grant at once and gives requester 0 priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         last_q   <= IDW'(N - 1);
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         last_q   <= last_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = |gnt_q;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Self-checking bench for sync_rr_arbiter (N=4); honours SYNC_RR_THREE_STAGE_EN.
module tb_sync_rr_arbiter;

   localparam int N = 4;
`ifdef SYNC_RR_THREE_STAGE_EN
   localparam int S = 3;
`else
   localparam int S = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b1111;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;

   logic       rst_next = 1'b0;
   logic [3:0] req_next = 4'b1111;

   int errors = 0;
   int checks = 0;

   sync_rr_arbiter #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt),
      .gnt_id(gnt_id),
      .busy  (busy)
   );

   always #20 clk = ~clk;

   // Reference model: requests become visible S edges after they are sampled.
   logic [3:0] hist[$];
   int         m_state;  // 0 idle, 1 granted, 2 gap
   logic [3:0] m_gnt;
   int         m_id;
   int         m_last;

   task automatic model_step(input logic r, input logic [3:0] rq);
      logic [3:0] rs;
      if (!r) begin
         hist.delete();
         for (int i = 0; i < S; i++) hist.push_back(4'b0000);
         m_state = 0;
         m_gnt   = 4'b0000;
         m_id    = 0;
         m_last  = N - 1;
      end else begin
         rs = hist.pop_front();
         hist.push_back(rq);
         case (m_state)
            0: begin
               for (int i = 1; i <= N; i++) begin
                  int c;
                  c = (m_last + i) % N;
                  if (rs[c]) begin
                     m_gnt   = 4'b0000;
                     m_gnt[c] = 1'b1;
                     m_id    = c;
                     m_state = 1;
                     break;
                  end
               end
            end
            1: begin
               if (!rs[m_id]) begin
                  m_gnt   = 4'b0000;
                  m_last  = m_id;
                  m_state = 2;
               end
            end
            default: m_state = 0;
         endcase
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: model sees pre-edge inputs, new inputs go in 10 ns after the edge,
   // outputs are compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step(rst_n, req);
      #10;
      rst_n = rst_next;
      req   = req_next;
      #10;
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("gnt_id", 32'(gnt_id), 32'(m_id[1:0]));
      check("busy", 32'(busy), 32'(|m_gnt));
      check("onehot", 32'($onehot0(gnt)), 32'd1);
   endtask

   typedef struct {
      logic [3:0] req;
      int         extra;  // edges beyond the plain request-to-grant latency
      logic [3:0] gnt;
      logic [1:0] id;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{4'b0100, 0, 4'b0100, 2'd2};  // single requester
      vecs[1] = '{4'b0000, 0, 4'b0000, 2'd2};  // release, id held
      vecs[2] = '{4'b0011, 0, 4'b0001, 2'd0};  // after 2: 0 before 1
      vecs[3] = '{4'b0010, 2, 4'b0010, 2'd1};  // release + GAP + IDLE decision
      vecs[4] = '{4'b0000, 0, 4'b0000, 2'd1};
      vecs[5] = '{4'b1000, 0, 4'b1000, 2'd3};
      vecs[6] = '{4'b0000, 0, 4'b0000, 2'd3};
      vecs[7] = '{4'b1001, 0, 4'b0001, 2'd0};  // after 3 wraps to 0
      vecs[8] = '{4'b0000, 0, 4'b0000, 2'd0};

      // Reset held with all requests high: nothing granted until S+1 edges after release.
      tick();
      tick();
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_id", 32'(gnt_id), 32'd0);
      rst_next = 1'b1;
      tick();
      for (int k = 1; k <= S; k++) begin
         tick();
         check("no_early_grant", 32'(gnt), 32'd0);
      end
      tick();
      check("first_grant", 32'(gnt), 32'h1);
      check("first_id", 32'(gnt_id), 32'd0);
      req_next = 4'b0000;
      for (int k = 0; k < S + 4; k++) tick();
      check("idle_busy", 32'(busy), 32'd0);

      // Table-driven single transactions with exact latency.
      foreach (vecs[v]) begin
         req_next = vecs[v].req;
         tick();
         for (int k = 1; k <= S + 1 + vecs[v].extra; k++) begin
            tick();
            if (k == S + vecs[v].extra) check("vec_not_early", 32'(gnt == vecs[v].gnt), 32'd0);
         end
         check("vec_gnt", 32'(gnt), 32'(vecs[v].gnt));
         check("vec_id", 32'(gnt_id), 32'(vecs[v].id));
         check("vec_busy", 32'(busy), 32'(|vecs[v].gnt));
         tick();
         tick();
      end

      // Reset in the middle of a grant to requester 3.
      req_next = 4'b1000;
      tick();
      for (int k = 1; k <= S + 1; k++) tick();
      check("pre_reset_gnt", 32'(gnt), 32'h8);
      req_next = 4'b1001;
      rst_next = 1'b0;
      tick();
      rst_next = 1'b1;
      tick();
      check("midreset_gnt", 32'(gnt), 32'd0);
      check("midreset_id", 32'(gnt_id), 32'd0);
      for (int k = 1; k <= S + 1; k++) tick();
      check("post_reset_favour", 32'(gnt), 32'h1);
      req_next = 4'b0000;
      for (int k = 0; k < S + 4; k++) tick();

      // Rotation: all request, each drops for 4 cycles after its grant.
      rst_next = 1'b0;
      tick();
      tick();
      rst_next = 1'b1;
      tick();
      begin
         int         cnt[4];
         int         ngr;
         int         zeros;
         logic [3:0] prev;
         ngr   = 0;
         zeros = 0;
         prev  = 4'b0000;
         foreach (cnt[i]) cnt[i] = 0;
         req_next = 4'b1111;
         for (int cyc = 0; cyc < 120 && ngr < 5; cyc++) begin
            tick();
            if (gnt != 4'b0000 && prev == 4'b0000) begin
               int idx;
               idx = -1;
               for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
               // GAP cycle plus the IDLE decision cycle
               if (ngr > 0) check("rot_gap", 32'(zeros), 32'd2);
               check("rot_order", 32'(idx), 32'(ngr % 4));
               ngr++;
               zeros = 0;
            end else if (gnt == 4'b0000 && ngr > 0) begin
               zeros++;
            end
            prev = gnt;
            for (int i = 0; i < 4; i++) begin
               if (gnt[i] && req_next[i] && cnt[i] == 0) begin
                  req_next[i] = 1'b0;
                  cnt[i] = 4;
               end else if (cnt[i] > 0) begin
                  cnt[i]--;
                  if (cnt[i] == 0) req_next[i] = 1'b1;
               end
            end
         end
         check("rot_count", 32'(ngr), 32'd5);
      end
      req_next = 4'b0000;
      rst_next = 1'b0;
      tick();
      tick();
      rst_next = 1'b1;
      tick();

      // Random traffic obeying the handshake, checked every cycle against the model.
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (req_next[i] && m_gnt[i] && $urandom_range(0, 2) == 0) req_next[i] = 1'b0;
            else if (!req_next[i] && !m_gnt[i] && $urandom_range(0, 3) == 0) req_next[i] = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
